vector_reg_file: RTL

- Multi-lane vector register file for the Decode stage; parametrised successor of the scalar register file.
- Each register holds LANES elements of DATA_WIDTH bits.
- Adds:
  - asynchronous clear
  - per-lane write masking
  - optional write-to-read bypass
  - optional hardwired-zero register
  - a busy-bit scoreboard (set at issue, cleared at writeback) that Decode uses for hazard stalls.

---
 rtl/vector_reg_file.sv | 109 ++++++++++
 1 files changed

// File: rtl/vector_reg_file.sv
// Multi-lane vector register file for Decode: per-lane masked writeback,
// optional write-to-read forwarding, optional hardwired-zero register 0,
// and a busy-bit scoreboard set at issue and cleared at writeback.
module vector_reg_file #(
  parameter int DATA_WIDTH   = 48,
  parameter int LANES        = 4,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDRESSWIDTH-1:0]       ra1,
  input  logic [ADDRESSWIDTH-1:0]       ra2,
  output logic [LANES*DATA_WIDTH-1:0]   rd1,
  output logic [LANES*DATA_WIDTH-1:0]   rd2,
  output logic                          busy1,
  output logic                          busy2,
  input  logic                          we3,
  input  logic [ADDRESSWIDTH-1:0]       wa3,
  input  logic [LANES*DATA_WIDTH-1:0]   wd3,
  input  logic [LANES-1:0]              wmask3,
  input  logic                          iss_valid,
  input  logic [ADDRESSWIDTH-1:0]       iss_addr,
  output logic [REGNUM-1:0]             busy_vec
);

  localparam int VW = LANES * DATA_WIDTH;

  logic [VW-1:0]     regs [REGNUM];
  logic [REGNUM-1:0] busy;
  logic              w_ok;
  logic              iss_ok;

  // An address names real, writable storage: in range and not the hardwired zero.
  function automatic logic usable(input logic [ADDRESSWIDTH-1:0] a);
    logic ok;
    ok = (32'(a) < 32'(REGNUM));
    if (ZERO_REG != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  // Forwarding applies only when the same-cycle write actually lands somewhere.
  function automatic logic fwd_hit(input logic [ADDRESSWIDTH-1:0] ra);
    return (BYPASS != 0) && w_ok && (ra == wa3);
  endfunction

  // Read value for one port: stored lanes, with masked lanes overlaid on a forward hit.
  function automatic logic [VW-1:0] read_port(input logic [ADDRESSWIDTH-1:0] ra);
    logic [VW-1:0] v;
    v = '0;
    if (rst_n && usable(ra)) begin
      v = regs[ra];
      if (fwd_hit(ra)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (wmask3[l]) v[l*DATA_WIDTH +: DATA_WIDTH] = wd3[l*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    return v;
  endfunction

  // Busy for one port: registered bit, masked off when the data is forwarded now.
  function automatic logic busy_port(input logic [ADDRESSWIDTH-1:0] ra);
    logic b;
    b = 1'b0;
    if (rst_n && usable(ra)) b = busy[ra];
    if (fwd_hit(ra)) b = 1'b0;
    return b;
  endfunction

  // Qualified write and issue strobes.
  always_comb begin
    w_ok   = we3 && usable(wa3);
    iss_ok = iss_valid && usable(iss_addr);
  end

  // Register storage: async clear, per-lane masked writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < REGNUM; r++) regs[r] <= '0;
    end else if (w_ok) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (wmask3[l]) regs[wa3][l*DATA_WIDTH +: DATA_WIDTH] <= wd3[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Scoreboard: writeback clears, issue sets; the later set wins on the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (w_ok)   busy[wa3]      <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  // Combinational read ports and busy outputs.
  always_comb begin
    rd1      = read_port(ra1);
    rd2      = read_port(ra2);
    busy1    = busy_port(ra1);
    busy2    = busy_port(ra2);
    busy_vec = rst_n ? busy : '0;
  end

endmodule
